// File: rtl/pulse_event_mux.sv
// pulse_event_mux: per-channel pulse counters serialised round-robin onto a valid/ready event stream
module pulse_event_mux #(
  parameter int N_CH = 4,
  parameter int CNT_W = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_CH-1:0]   i_pulse,
  input  logic [N_CH-1:0]   i_ovf_clr,
  output logic [N_CH-1:0]   o_pending,
  output logic [N_CH-1:0]   o_overflow,
  output logic              o_valid,
  output logic [CH_W-1:0]   o_chan,
  input  logic              i_ready
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] cnt_nxt [N_CH];
  logic [CH_W-1:0]  rr_last, g, idx;
  logic [N_CH-1:0]  dec, drop;
  logic             any, load;
  // round-robin pick starting just after the last granted channel, registered counts only
  always_comb begin
    g = rr_last;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CH_W'((int'(rr_last) + i) % N_CH);
      if (!any && cnt[idx] != '0) begin
        g = idx;
        any = 1'b1;
      end
    end
  end
  // next count per channel: a pulse adds, a grant removes, a pulse into a full counter is dropped
  always_comb begin
    load = !o_valid | i_ready;
    for (int k = 0; k < N_CH; k++) begin
      o_pending[k] = cnt[k] != '0;
      dec[k] = load & any & (g == CH_W'(k));
      drop[k] = i_pulse[k] & !dec[k] & (cnt[k] == MAX);
      cnt_nxt[k] = drop[k] ? cnt[k] : cnt[k] + CNT_W'(i_pulse[k]) - CNT_W'(dec[k]);
    end
  end
  // counters, sticky overflow and the output event register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
      o_overflow <= '0;
      o_valid <= 1'b0;
      o_chan <= '0;
      rr_last <= CH_W'(N_CH - 1);
    end else begin
      for (int k = 0; k < N_CH; k++) cnt[k] <= cnt_nxt[k];
      o_overflow <= drop | (o_overflow & ~i_ovf_clr);
      if (load) begin
        o_valid <= any;
        if (any) begin
          o_chan <= g;
          rr_last <= g;
        end
      end
    end
  end
endmodule

// File: tb/tb_pulse_event_mux.sv
// tb_pulse_event_mux: directed and random checks of pulse_event_mux against a pending-count model
module tb_pulse_event_mux;
  localparam int N = 4;
  localparam int MAXC = 15;
  logic clk = 1'b0, rst = 1'b0, ready = 1'b0;
  logic [N-1:0] pulse = '0, clr = '0;
  logic [N-1:0] o_pending, o_overflow;
  logic o_valid;
  logic [1:0] o_chan;
  int checks = 0, errors = 0;
  int m_cnt [N];
  bit m_ovf [N];
  bit m_v;
  int m_ch = 0, m_last = N - 1;
  int hs [N];
  int hs_tot = 0;
  bit p_v, p_rdy, p_rst;
  logic [1:0] p_ch;
  int pend3_hs, lat3;
  bit got3;
  logic [N-1:0] rp;

  pulse_event_mux #(.N_CH(N), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_ovf_clr(clr),
    .o_pending(o_pending), .o_overflow(o_overflow), .o_valid(o_valid),
    .o_chan(o_chan), .i_ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: pending events as integer counts, one held event, pointer to last served channel
  task automatic model_edge();
    int g;
    bit ld, dc, dr;
    if (rst) begin
      for (int k = 0; k < N; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; end
      m_v = 0; m_ch = 0; m_last = N - 1;
    end else begin
      ld = !m_v || ready;
      g = -1;
      for (int i = 1; i <= N; i++)
        if (g < 0 && m_cnt[(m_last + i) % N] > 0) g = (m_last + i) % N;
      for (int k = 0; k < N; k++) begin
        dc = ld && (g == k);
        dr = pulse[k] && !dc && m_cnt[k] == MAXC;
        if (!dr) m_cnt[k] = m_cnt[k] + int'(pulse[k]) - int'(dc);
        m_ovf[k] = dr || (m_ovf[k] && !clr[k]);
      end
      if (ld) begin
        m_v = (g >= 0);
        if (g >= 0) begin m_ch = g; m_last = g; end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] p, input logic [N-1:0] c, input logic r, input logic rs);
    logic [N-1:0] ep, eo;
    pulse = p; clr = c; ready = r; rst = rs;
    if (!rs && o_valid && r) begin hs[o_chan]++; hs_tot++; end
    p_v = o_valid; p_rdy = r; p_rst = rs; p_ch = o_chan;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin ep[k] = m_cnt[k] != 0; eo[k] = m_ovf[k]; end
    chk("valid", 32'(o_valid), 32'(m_v));
    chk("chan", 32'(o_chan), m_ch);
    chk("pending", 32'(o_pending), 32'(ep));
    chk("overflow", 32'(o_overflow), 32'(eo));
    if (p_v && !p_rdy && !p_rst) begin
      chk("hold_valid", 32'(o_valid), 1);
      chk("hold_chan", 32'(o_chan), 32'(p_ch));
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) hs[k] = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) step(N'($urandom), '0, 1'b0, 1'b1);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_pending", 32'(o_pending), 0);
    chk("rst_overflow", 32'(o_overflow), 0);
    chk("rst_chan", 32'(o_chan), 0);
    for (int i = 0; i < 5; i++) begin
      step('0, '0, 1'b1, 1'b0);
      chk("idle_valid", 32'(o_valid), 0);
    end
    step(4'b0100, '0, 1'b1, 1'b0);
    chk("single_pend_t1", 32'(o_pending), 4'b0100);
    chk("single_valid_t1", 32'(o_valid), 0);
    step('0, '0, 1'b1, 1'b0);
    chk("single_valid_t2", 32'(o_valid), 1);
    chk("single_chan_t2", 32'(o_chan), 2);
    chk("single_pend_t2", 32'(o_pending), 0);
    step('0, '0, 1'b1, 1'b0);
    chk("single_valid_t3", 32'(o_valid), 0);

    step(N'($urandom), '0, 1'b0, 1'b1);
    step(4'b1111, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("simul_valid", 32'(o_valid), 1);
      chk("simul_chan", 32'(o_chan), i);
      step('0, '0, 1'b1, 1'b0);
    end
    chk("simul_done", 32'(o_valid), 0);

    step('0, '0, 1'b0, 1'b1);
    hs_tot = 0; pend3_hs = -1; got3 = 0; lat3 = 99;
    for (int i = 0; i < 16; i++) begin
      step(4'b0001 | ((i == 2) ? 4'b1000 : 4'b0000), '0, (i % 2 == 0), 1'b0);
      if (o_pending[3] && pend3_hs < 0) pend3_hs = hs_tot;
      if (o_valid && o_chan == 2'd3 && !got3) begin got3 = 1; lat3 = hs_tot - pend3_hs; end
    end
    chk("fair_ch3_granted", 32'(got3), 1);
    chk("fair_ch3_within2", 32'(lat3 <= 2), 1);
    for (int i = 0; i < 30; i++) step('0, '0, 1'b1, 1'b0);
    chk("fair_drained", 32'(o_valid), 0);

    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(4'b0010, '0, 1'b0, 1'b0);
    chk("sat_ovf_before17", 32'(o_overflow[1]), 0);
    step(4'b0010, '0, 1'b0, 1'b0);
    chk("sat_ovf_after17", 32'(o_overflow[1]), 1);
    chk("sat_valid", 32'(o_valid), 1);
    chk("sat_chan", 32'(o_chan), 1);
    step(4'b0010, 4'b0010, 1'b0, 1'b0);
    chk("clr_vs_drop", 32'(o_overflow[1]), 1);
    step('0, 4'b0010, 1'b0, 1'b0);
    chk("clr_alone", 32'(o_overflow[1]), 0);
    for (int k = 0; k < N; k++) hs[k] = 0;
    hs_tot = 0;
    for (int i = 0; i < 25; i++) step('0, '0, 1'b1, 1'b0);
    chk("sat_hs_ch1", hs[1], 16);
    chk("sat_hs_total", hs_tot, 16);

    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b0001, '0, 1'b0, 1'b0);
    chk("mid_held", 32'(o_valid), 1);
    chk("mid_pending", 32'(o_pending), 4'b0001);
    step('0, '0, 1'b0, 1'b1);
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_pending", 32'(o_pending), 0);
    hs_tot = 0;
    for (int i = 0; i < 10; i++) step('0, '0, 1'b1, 1'b0);
    chk("mid_no_events", hs_tot, 0);

    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) rp[k] = ($urandom_range(0, 2) == 0);
      step(rp, ($urandom_range(0, 9) == 0) ? N'($urandom) : '0,
           (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 149) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
